// File: rtl/spi_pkg.sv
// spi_pkg: command codes, word widths and state encoding shared by the SPI slave and spi_ram.
package spi_pkg;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam int SPI_WORD_W = 10;
    localparam int SPI_DATA_W = 8;
    typedef enum logic {ST_IDLE, ST_HOLD} ram_state_t;
endpackage

// File: rtl/ram_core.sv
// ram_core: single-port synchronous array with write enable and registered, enable-gated read data.
module ram_core #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/spi_ram.sv
// spi_ram: decodes SPI slave command words into memory writes/reads and holds each read byte
// on dout with tx_valid asserted for TX_HOLD cycles.
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SPI_WORD_W-1:0] din,
    input  logic                  rx_valid,
    output logic [SPI_DATA_W-1:0] dout,
    output logic                  tx_valid
);
    localparam int CW = $clog2(TX_HOLD + 1);

    logic [1:0]            cmd;
    logic [ADDR_SIZE-1:0]  wr_addr, rd_addr, rd_addr_eff, ram_addr;
    logic                  rd_addr_ok, rd_seen, rd_oor;
    logic                  is_wr, is_rd, wr_in, rd_in;
    logic [CW-1:0]         cnt;
    logic [SPI_DATA_W-1:0] rdata;
    ram_state_t            state;

    assign cmd         = din[SPI_WORD_W-1 -: 2];
    assign is_wr       = rx_valid && cmd == CMD_WR_DATA;
    assign is_rd       = rx_valid && cmd == CMD_RD_DATA;
    // Reads target address 0 until the first RD_ADDR after reset.
    assign rd_addr_eff = rd_addr_ok ? rd_addr : '0;
    assign wr_in       = 32'(wr_addr) < MEM_DEPTH;
    assign rd_in       = 32'(rd_addr_eff) < MEM_DEPTH;
    assign ram_addr    = is_rd ? rd_addr_eff : wr_addr;
    // rdata has no reset, so dout is forced to 0 until a read happens and for out-of-range reads.
    assign dout        = (rd_seen && !rd_oor) ? rdata : '0;

    ram_core #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE), .DW(SPI_DATA_W)) u_core (
        .clk   (clk),
        .we    (is_wr && wr_in),
        .re    (is_rd && rd_in),
        .addr  (ram_addr),
        .wdata (din[SPI_DATA_W-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_addr_ok <= 1'b0;
            rd_seen    <= 1'b0;
            rd_oor     <= 1'b0;
            cnt        <= '0;
            tx_valid   <= 1'b0;
        end else begin
            if (rx_valid && cmd == CMD_WR_ADDR) wr_addr <= din[ADDR_SIZE-1:0];
            if (rx_valid && cmd == CMD_RD_ADDR) begin
                rd_addr    <= din[ADDR_SIZE-1:0];
                rd_addr_ok <= 1'b1;
            end
            if (is_rd) begin
                state    <= ST_HOLD;
                rd_seen  <= 1'b1;
                rd_oor   <= !rd_in;
                cnt      <= CW'(TX_HOLD);
                tx_valid <= 1'b1;
            end else if (state == ST_HOLD) begin
                if (cnt <= CW'(1)) begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    tx_valid <= 1'b0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule
